// File: rtl/mem_stage_if.sv
// Signal bundle between mem_stage and its surroundings: EX handoff, data-memory port and writeback.
// The slave modport is the mem_stage view; master is the environment driving EX and memory.
interface mem_stage_if #(
  parameter int ADDR_W = 14
);
  logic              ex_valid;
  logic              ex_ready;
  logic [2:0]        ex_rd;
  logic [15:0]       ex_rs1;
  logic [15:0]       ex_data;
  logic [1:0]        ex_fn;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic              wb_we;
  logic [2:0]        wb_rd;
  logic [15:0]       wb_data;
  logic              err;

  modport master (
    output ex_valid, ex_rd, ex_rs1, ex_data, ex_fn, mem_ack, mem_rdata,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_we, wb_rd, wb_data, err
  );

  modport slave (
    input  ex_valid, ex_rd, ex_rs1, ex_data, ex_fn, mem_ack, mem_rdata,
    output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_we, wb_rd, wb_data, err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-stage responder: ALU writeback, loads and stores over a req/ack port, EX back-pressure.
// Define MEM_TIMEOUT_EN to abort requests unanswered for TIMEOUT cycles (err pulses once).
module mem_stage #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 16
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t            state_p1, state_nxt;
  logic              req_p1, req_nxt;
  logic              we_p1, we_nxt;
  logic [ADDR_W-1:0] addr_p1, addr_nxt;
  logic [15:0]       wdata_p1, wdata_nxt;
  logic [2:0]        rd_p1, rd_nxt;
  logic              wb_we_p1, wb_we_nxt;
  logic [2:0]        wb_rd_p1, wb_rd_nxt;
  logic [15:0]       wb_data_p1, wb_data_nxt;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  cnt_p1, cnt_nxt;
  logic              err_p1, err_nxt;
`endif

  always_comb begin
    state_nxt   = state_p1;
    req_nxt     = req_p1;
    we_nxt      = we_p1;
    addr_nxt    = addr_p1;
    wdata_nxt   = wdata_p1;
    rd_nxt      = rd_p1;
    wb_we_nxt   = 1'b0;
    wb_rd_nxt   = wb_rd_p1;
    wb_data_nxt = wb_data_p1;
`ifdef MEM_TIMEOUT_EN
    cnt_nxt     = cnt_p1;
    err_nxt     = 1'b0;
`endif
    unique case (state_p1)
      IDLE: begin
        if (bus.ex_valid) begin
          case (bus.ex_fn)
            2'b00: begin
              wb_we_nxt   = 1'b1;
              wb_rd_nxt   = bus.ex_rd;
              wb_data_nxt = bus.ex_rs1;
            end
            2'b01, 2'b10: begin
              state_nxt = (bus.ex_fn == 2'b01) ? LOAD : STORE;
              req_nxt   = 1'b1;
              we_nxt    = (bus.ex_fn == 2'b10);
              addr_nxt  = bus.ex_rs1[ADDR_W-1:0];
              rd_nxt    = bus.ex_rd;
              if (bus.ex_fn == 2'b10) wdata_nxt = bus.ex_data;
`ifdef MEM_TIMEOUT_EN
              cnt_nxt   = '0;
`endif
            end
            default: ;
          endcase
        end
      end
      LOAD, STORE: begin
        // An ack is checked before the timeout so a same-cycle ack completes normally.
        if (bus.mem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
          if (state_p1 == LOAD) begin
            wb_we_nxt   = 1'b1;
            wb_rd_nxt   = rd_p1;
            wb_data_nxt = bus.mem_rdata;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_p1 == CNT_W'(TIMEOUT - 1)) begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_p1 + 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1   <= IDLE;
      req_p1     <= 1'b0;
      we_p1      <= 1'b0;
      addr_p1    <= '0;
      wdata_p1   <= '0;
      rd_p1      <= '0;
      wb_we_p1   <= 1'b0;
      wb_rd_p1   <= '0;
      wb_data_p1 <= '0;
    end else begin
      state_p1   <= state_nxt;
      req_p1     <= req_nxt;
      we_p1      <= we_nxt;
      addr_p1    <= addr_nxt;
      wdata_p1   <= wdata_nxt;
      rd_p1      <= rd_nxt;
      wb_we_p1   <= wb_we_nxt;
      wb_rd_p1   <= wb_rd_nxt;
      wb_data_p1 <= wb_data_nxt;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p1 <= '0;
      err_p1 <= 1'b0;
    end else begin
      cnt_p1 <= cnt_nxt;
      err_p1 <= err_nxt;
    end
  end
  assign bus.err = err_p1;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.ex_ready  = (state_p1 == IDLE);
  assign bus.mem_req   = req_p1;
  assign bus.mem_we    = we_p1;
  assign bus.mem_addr  = addr_p1;
  assign bus.mem_wdata = wdata_p1;
  assign bus.wb_we     = wb_we_p1;
  assign bus.wb_rd     = wb_rd_p1;
  assign bus.wb_data   = wb_data_p1;
endmodule
